// File: rtl/uart_pkg.sv
// Shared UART constants: line timing, bit-FSM states, match-FSM states and the ASCII codes
// of the AT-command response terminators.
package uart_pkg;

   localparam int CLK  = 50_000_000;
   localparam int BAUD = 115200;
   localparam int DIV  = CLK / BAUD;
   localparam int HALF = DIV / 2;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
   typedef enum logic [1:0] {M_IDLE, M_O, M_K, M_CR} match_state_e;

   localparam logic [7:0] ASC_O  = 8'h4F;
   localparam logic [7:0] ASC_K  = 8'h4B;
   localparam logic [7:0] ASC_CR = 8'h0D;
   localparam logic [7:0] ASC_LF = 8'h0A;
   localparam logic [7:0] ASC_E  = 8'h45;
   localparam logic [7:0] ASC_R  = 8'h52;

   // Expected byte at each position of "ERROR\r\n".
   function automatic logic [7:0] err_char(input logic [2:0] idx);
      case (idx)
         3'd0:    err_char = ASC_E;
         3'd1:    err_char = ASC_R;
         3'd2:    err_char = ASC_R;
         3'd3:    err_char = ASC_O;
         3'd4:    err_char = ASC_R;
         3'd5:    err_char = ASC_CR;
         3'd6:    err_char = ASC_LF;
         default: err_char = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Bit-level 8N1 receiver: 2-FF synchroniser, baud counter and IDLE/START/DATA/STOP sampling FSM.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int DIV_P  = DIV,
   parameter int HALF_P = HALF
) (
   input  logic       iCLK,
   input  logic       RST_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err
);
   localparam int            CW       = $clog2(DIV_P);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF_P - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DIV_P - 1);

   logic          sync1_q, sync2_q, rx_prev_q;
   logic          rx_s;
   rx_state_e     state_q;
   logic [CW-1:0] cnt_baud_q;
   logic [2:0]    bit_cnt_q;
   logic [7:0]    shift_q;

   assign rx_s = sync2_q;

   always_ff @(posedge iCLK or negedge RST_n) begin
      if (!RST_n) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         sync1_q   <= rx;
         sync2_q   <= sync1_q;
         rx_prev_q <= rx_s;
      end
   end

   // A low stop bit leaves the line low, so the falling-edge test in IDLE
   // naturally waits for the line to return high before the next frame.
   always_ff @(posedge iCLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q    <= IDLE;
         cnt_baud_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         cnt_baud_q <= cnt_baud_q + CW'(1);
         case (state_q)
            IDLE: begin
               cnt_baud_q <= '0;
               if (rx_prev_q && !rx_s) state_q <= START;
            end
            START: begin
               if (cnt_baud_q == CNT_HALF) begin
                  cnt_baud_q <= '0;
                  bit_cnt_q  <= '0;
                  state_q    <= rx_s ? IDLE : DATA;
               end
            end
            DATA: begin
               if (cnt_baud_q == CNT_FULL) begin
                  cnt_baud_q <= '0;
                  shift_q    <= {rx_s, shift_q[7:1]};
                  bit_cnt_q  <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) state_q <= STOP;
               end
            end
            STOP: begin
               if (cnt_baud_q == CNT_FULL) begin
                  cnt_baud_q <= '0;
                  state_q    <= IDLE;
                  if (rx_s) begin
                     rx_data  <= shift_q;
                     rx_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_ok.sv
// UART receiver that scans the byte stream for "OK\r\n" and raises a sticky receiver_OK.
// Define UART_RX_ERR_DETECT_EN to add the independent "ERROR\r\n" matcher and receiver_ERR.
module uart_rx_ok #(
   parameter int CLK  = 50_000_000,
   parameter int BAUD = 115200
) (
   input  logic       iCLK,
   input  logic       RST_n,
   input  logic       rx,
   input  logic       receive_ok_en,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       receiver_OK
`ifdef UART_RX_ERR_DETECT_EN
   ,
   output logic       receiver_ERR
`endif
);
   import uart_pkg::*;

   localparam int DIV_T  = CLK / BAUD;
   localparam int HALF_T = DIV_T / 2;

   match_state_e m_state_q, m_state_d;
   logic         ok_hit;
   logic         ok_en_q;
   logic         flag_clr;

   uart_rx_core #(
      .DIV_P  (DIV_T),
      .HALF_P (HALF_T)
   ) u_core (
      .iCLK      (iCLK),
      .RST_n     (RST_n),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err)
   );

   assign flag_clr = receive_ok_en && !ok_en_q;

   // 'O' restarts the match from any state so "OOK\r\n" still hits.
   always_comb begin
      m_state_d = m_state_q;
      ok_hit    = 1'b0;
      if (frame_err) begin
         m_state_d = M_IDLE;
      end else if (rx_valid) begin
         m_state_d = M_IDLE;
         if (rx_data == ASC_O) begin
            m_state_d = M_O;
         end else begin
            case (m_state_q)
               M_O:     if (rx_data == ASC_K)  m_state_d = M_K;
               M_K:     if (rx_data == ASC_CR) m_state_d = M_CR;
               M_CR:    if (rx_data == ASC_LF) ok_hit = 1'b1;
               default: m_state_d = M_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge iCLK or negedge RST_n) begin
      if (!RST_n) begin
         m_state_q   <= M_IDLE;
         ok_en_q     <= 1'b0;
         receiver_OK <= 1'b0;
      end else begin
         m_state_q <= m_state_d;
         ok_en_q   <= receive_ok_en;
         if (ok_hit)        receiver_OK <= 1'b1;
         else if (flag_clr) receiver_OK <= 1'b0;
      end
   end

`ifdef UART_RX_ERR_DETECT_EN
   logic [2:0] err_idx_q, err_idx_d;
   logic       err_hit;

   always_comb begin
      err_idx_d = err_idx_q;
      err_hit   = 1'b0;
      if (frame_err) begin
         err_idx_d = '0;
      end else if (rx_valid) begin
         if (rx_data == err_char(err_idx_q)) begin
            if (err_idx_q == 3'd6) begin
               err_hit   = 1'b1;
               err_idx_d = '0;
            end else begin
               err_idx_d = err_idx_q + 3'd1;
            end
         end else if (rx_data == ASC_E) begin
            err_idx_d = 3'd1;
         end else begin
            err_idx_d = '0;
         end
      end
   end

   always_ff @(posedge iCLK or negedge RST_n) begin
      if (!RST_n) begin
         err_idx_q    <= '0;
         receiver_ERR <= 1'b0;
      end else begin
         err_idx_q <= err_idx_d;
         if (err_hit)       receiver_ERR <= 1'b1;
         else if (flag_clr) receiver_ERR <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_uart_rx_ok.sv
// Self-checking bench for uart_rx_ok: scoreboard of expected bytes/frame errors plus flag checks.
module tb_uart_rx_ok;
   localparam int CLK_HZ = 50_000_000;
   localparam int BAUD_R = 500_000;
   localparam int DIV    = CLK_HZ / BAUD_R;   // 100
   localparam int HALF   = DIV / 2;           // 50
   localparam int LAT    = 2 + 1 + HALF + 9 * DIV;

   typedef struct packed {
      logic       ferr;
      logic [7:0] data;
   } exp_t;
   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic       receive_ok_en;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       receiver_ok;
`ifdef UART_RX_ERR_DETECT_EN
   logic       receiver_err;
`endif

   exp_t       exp_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         out_cnt  = 0;
   int         start_cyc;
   int         last_valid_cyc = 0;
   int         ok_rise_cyc    = 0;
   logic       ok_prev = 1'b0;
   logic [7:0] last_exp = 8'h00;

   uart_rx_ok #(.CLK(CLK_HZ), .BAUD(BAUD_R)) dut (
      .iCLK          (clk),
      .RST_n         (rst_n),
      .rx            (rx),
      .receive_ok_en (receive_ok_en),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .frame_err     (frame_err),
      .receiver_OK   (receiver_ok)
`ifdef UART_RX_ERR_DETECT_EN
      ,
      .receiver_ERR  (receiver_err)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Output monitor: every rx_valid / frame_err pulse is matched against the scoreboard.
   always @(negedge clk) begin
      if (rst_n && (rx_valid || frame_err)) begin
         exp_t e;
         out_cnt++;
         if (rx_valid) last_valid_cyc = cyc;
         $display("t=%0d cyc=%0d %s rx_data=0x%02h", $time, cyc,
                  frame_err ? "frame_err" : "rx_valid ", rx_data);
         if (exp_q.size() == 0) begin
            check_eq("spurious_output", {30'd0, frame_err, rx_valid}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq("out_kind_ferr", {31'd0, frame_err}, {31'd0, e.ferr});
            check_eq("out_valid", {31'd0, rx_valid}, {31'd0, !e.ferr});
            check_eq("out_data", {24'd0, rx_data}, {24'd0, e.data});
         end
      end
      if (receiver_ok && !ok_prev) ok_rise_cyc = cyc;
      ok_prev = receiver_ok;
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      exp_t e;
      e.ferr = !stop;
      e.data = stop ? b : last_exp;
      if (stop) last_exp = b;
      exp_q.push_back(e);
      start_cyc = cyc;
      rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (DIV) @(negedge clk);
      end
      rx = stop;
      repeat (DIV) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic send_seq(input bq_t seq);
      foreach (seq[i]) send_byte(seq[i], 1'b1);
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 3 * DIV && exp_q.size() != 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      #1;
      check_eq(tag, exp_q.size(), 32'd0);
   endtask

   task automatic pulse_clear();
      receive_ok_en = 1'b1;
      repeat (3) @(negedge clk);
      receive_ok_en = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t seq;
      int  n_before;
      int  lat;

      rx = 1'b1;
      receive_ok_en = 1'b0;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("rst_rx_data", {24'd0, rx_data}, 32'h00);
      check_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check_eq("rst_receiver_ok", {31'd0, receiver_ok}, 32'd0);
`ifdef UART_RX_ERR_DETECT_EN
      check_eq("rst_receiver_err", {31'd0, receiver_err}, 32'd0);
`endif
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // Single byte, ideal timing, latency window.
      send_byte(8'h55, 1'b1);
      wait_drain("drain_0x55");
      lat = last_valid_cyc - start_cyc;
      check_eq("latency_window", {31'd0, (lat >= LAT - 1 && lat <= LAT + 1)}, 32'd1);

      // Short low glitch (well under half a bit) must be rejected.
      n_before = out_cnt;
      rx = 1'b0;
      repeat (23) @(negedge clk);
      rx = 1'b1;
      repeat (2 * DIV) @(negedge clk);
      check_eq("glitch_no_output", out_cnt, n_before);

      // Frame error keeps previous data, next byte still good.
      send_byte(8'h41, 1'b0);
      repeat (DIV) @(negedge clk);
      send_byte(8'h42, 1'b1);
      wait_drain("drain_ferr");
      check_eq("rx_data_after_ferr", {24'd0, rx_data}, 32'h42);

      // "xxOOK\r\n" back-to-back.
      check_eq("ok_before_seq", {31'd0, receiver_ok}, 32'd0);
      seq = '{8'h78, 8'h78, 8'h4F, 8'h4F, 8'h4B, 8'h0D, 8'h0A};
      send_seq(seq);
      wait_drain("drain_ok_seq");
      check_eq("ok_set", {31'd0, receiver_ok}, 32'd1);
      check_eq("ok_rise_delay", ok_rise_cyc - last_valid_cyc, 32'd1);
      repeat (50) @(negedge clk);
      check_eq("ok_sticky", {31'd0, receiver_ok}, 32'd1);
      pulse_clear();
      check_eq("ok_cleared", {31'd0, receiver_ok}, 32'd0);

      // Broken terminator must not match.
      seq = '{8'h4F, 8'h4B, 8'h0D, 8'h58, 8'h0A};
      send_seq(seq);
      wait_drain("drain_broken");
      check_eq("ok_broken_seq", {31'd0, receiver_ok}, 32'd0);

      // A frame error between \r and \n breaks the match.
      seq = '{8'h4F, 8'h4B, 8'h0D};
      send_seq(seq);
      send_byte(8'h0A, 1'b0);
      repeat (DIV) @(negedge clk);
      send_byte(8'h0A, 1'b1);
      wait_drain("drain_ferr_seq");
      check_eq("ok_ferr_breaks", {31'd0, receiver_ok}, 32'd0);

      // Reset in the middle of the final byte of "OK\r\n".
      seq = '{8'h4F, 8'h4B, 8'h0D};
      send_seq(seq);
      wait_drain("drain_pre_reset");
      n_before = out_cnt;
      rx = 1'b0; repeat (DIV) @(negedge clk);
      rx = 1'b0; repeat (DIV) @(negedge clk);
      rx = 1'b1; repeat (DIV) @(negedge clk);
      rst_n = 1'b0;
      rx = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("mid_rst_rx_data", {24'd0, rx_data}, 32'h00);
      rst_n = 1'b1;
      last_exp = 8'h00;
      repeat (2 * DIV) @(negedge clk);
      check_eq("mid_rst_no_pulse", out_cnt, n_before);
      check_eq("mid_rst_ok_low", {31'd0, receiver_ok}, 32'd0);
      seq = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
      send_seq(seq);
      wait_drain("drain_post_reset");
      check_eq("ok_after_reset", {31'd0, receiver_ok}, 32'd1);

`ifdef UART_RX_ERR_DETECT_EN
      pulse_clear();
      check_eq("ok_cleared_2", {31'd0, receiver_ok}, 32'd0);
      seq = '{8'h45, 8'h52, 8'h52, 8'h4F, 8'h52, 8'h0D, 8'h0A};
      send_seq(seq);
      wait_drain("drain_error");
      check_eq("err_set", {31'd0, receiver_err}, 32'd1);
      check_eq("err_ok_low", {31'd0, receiver_ok}, 32'd0);
`endif

      repeat (10) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
